// File: rtl/calu_pkg.sv
// rtl/calu_pkg.sv - opcode/state enums and flag bit positions shared by complex_alu_mc
package calu_pkg;

    typedef enum logic [3:0] {
        OP_CADD  = 4'd0,
        OP_CSUB  = 4'd1,
        OP_CMUL  = 4'd2,
        OP_CDIV  = 4'd3,
        OP_CINC  = 4'd4,
        OP_CDEC  = 4'd5,
        OP_CSWAP = 4'd6,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_XOR   = 4'd10,
        OP_XNOR  = 4'd11,
        OP_NAND  = 4'd12,
        OP_NOR   = 4'd13
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    localparam int NUM_FLAGS = 13;
    localparam int FLAG_ILL  = 12;
    localparam int FLAG_CR   = 11;
    localparam int FLAG_CI   = 10;
    localparam int FLAG_OR   = 9;
    localparam int FLAG_OI   = 8;
    localparam int FLAG_ZR   = 7;
    localparam int FLAG_ZI   = 6;
    localparam int FLAG_NR   = 5;
    localparam int FLAG_NI   = 4;
    localparam int FLAG_DVFR = 3;
    localparam int FLAG_DVFI = 2;
    localparam int FLAG_ZER  = 1;
    localparam int FLAG_ZEI  = 0;

endpackage

// File: rtl/calu_seq_div.sv
// rtl/calu_seq_div.sv - unsigned restoring divider, one quotient bit per cycle, start/done handshake
module calu_seq_div #(
    parameter int N = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N:0]    shifted;
    logic [N:0]    diff;

    // done is a single-cycle pulse so a stale value can never be seen by the next operation
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[N]) begin
                rem_d = diff[N-1:0];
                quo_d = {quo_q[N-2:0], 1'b1};
            end else begin
                rem_d = shifted[N-1:0];
                quo_d = {quo_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/complex_alu_mc.sv
// rtl/complex_alu_mc.sv - multi-cycle complex ALU (add/sub/mul/div/inc/dec/swap); CALU_LOGIC_EN adds bitwise ops 8-13
module complex_alu_mc
    import calu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*W-1:0]       z1,
    input  logic [2*W-1:0]       z2,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W-1:0]       zout,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int PW = 2 * W;
    localparam int DW = 2 * W + 2;

    state_e               state_q, state_d;
    logic [2*W-1:0]       z1_q, z1_d, z2_q, z2_d;
    logic [2*W-1:0]       zout_q, zout_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;

    logic [W-1:0] a_in, b_in, c_in, d_in;
    assign a_in = z1[2*W-1:W];
    assign b_in = z1[W-1:0];
    assign c_in = z2[2*W-1:W];
    assign d_in = z2[W-1:0];

    logic accept, div_zero_in, div_start;
    assign accept      = in_valid && (state_q == S_IDLE);
    assign div_zero_in = (z2 == '0);
    assign div_start   = accept && (opcode == OP_CDIV) && !div_zero_in;

    function automatic logic fits_w(input logic [DW-1:0] v);
        fits_w = (&v[DW-1:W-1]) || !(|v[DW-1:W-1]);
    endfunction

    function automatic logic [NUM_FLAGS-1:0] value_flags(input logic [W-1:0] re, input logic [W-1:0] im);
        value_flags          = '0;
        value_flags[FLAG_ZR] = (re == '0);
        value_flags[FLAG_ZI] = (im == '0);
        value_flags[FLAG_NR] = re[W-1];
        value_flags[FLAG_NI] = im[W-1];
    endfunction

    // Multipliers see live inputs in IDLE so the dividers can be loaded on the accept edge
    logic [2*W-1:0] op1, op2;
    assign op1 = (state_q == S_IDLE) ? z1 : z1_q;
    assign op2 = (state_q == S_IDLE) ? z2 : z2_q;

    logic signed [PW-1:0] a_x, b_x, c_x, d_x;
    assign a_x = {{W{op1[2*W-1]}}, op1[2*W-1:W]};
    assign b_x = {{W{op1[W-1]}}, op1[W-1:0]};
    assign c_x = {{W{op2[2*W-1]}}, op2[2*W-1:W]};
    assign d_x = {{W{op2[W-1]}}, op2[W-1:0]};

    logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc, p_cc, p_dd;
    assign p_ac = a_x * c_x;
    assign p_bd = b_x * d_x;
    assign p_ad = a_x * d_x;
    assign p_bc = b_x * c_x;
    assign p_cc = c_x * c_x;
    assign p_dd = d_x * d_x;

    logic [DW-1:0] e_ac, e_bd, e_ad, e_bc;
    assign e_ac = {{2{p_ac[PW-1]}}, p_ac};
    assign e_bd = {{2{p_bd[PW-1]}}, p_bd};
    assign e_ad = {{2{p_ad[PW-1]}}, p_ad};
    assign e_bc = {{2{p_bc[PW-1]}}, p_bc};

    logic [DW-1:0] mul_re_x, mul_im_x, num_re, num_im, den;
    assign mul_re_x = e_ac - e_bd;
    assign mul_im_x = e_ad + e_bc;
    assign num_re   = e_ac + e_bd;
    assign num_im   = e_bc - e_ad;
    assign den      = {2'b00, p_cc} + {2'b00, p_dd};

    logic [DW-1:0] mag_re, mag_im, q_re, q_im, res_re, res_im;
    logic          done_re, done_im;
    assign mag_re = num_re[DW-1] ? -num_re : num_re;
    assign mag_im = num_im[DW-1] ? -num_im : num_im;

    calu_seq_div #(.N(DW)) u_div_re (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (mag_re),
        .divisor  (den),
        .quotient (q_re),
        .done     (done_re)
    );

    calu_seq_div #(.N(DW)) u_div_im (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (mag_im),
        .divisor  (den),
        .quotient (q_im),
        .done     (done_im)
    );

    // Numerator signs are recomputed from the held operands; the denominator is never negative
    assign res_re = num_re[DW-1] ? -q_re : q_re;
    assign res_im = num_im[DW-1] ? -q_im : q_im;

    logic [W:0] add_re, add_im, sub_re, sub_im;
    assign add_re = {1'b0, a_in} + {1'b0, c_in};
    assign add_im = {1'b0, b_in} + {1'b0, d_in};
    assign sub_re = {1'b0, a_in} + {1'b0, ~c_in} + (W+1)'(1);
    assign sub_im = {1'b0, b_in} + {1'b0, ~d_in} + (W+1)'(1);

    logic [W-1:0]         s_re, s_im;
    logic                 s_cr, s_ci, s_ovr, s_ovi, s_ze, s_ill;
    logic [NUM_FLAGS-1:0] s_flags;

    always_comb begin
        s_re  = '0;
        s_im  = '0;
        s_cr  = 1'b0;
        s_ci  = 1'b0;
        s_ovr = 1'b0;
        s_ovi = 1'b0;
        s_ze  = 1'b0;
        s_ill = 1'b0;
        case (opcode)
            OP_CADD: begin
                s_re  = add_re[W-1:0];
                s_im  = add_im[W-1:0];
                s_cr  = add_re[W];
                s_ci  = add_im[W];
                s_ovr = (a_in[W-1] == c_in[W-1]) && (add_re[W-1] != a_in[W-1]);
                s_ovi = (b_in[W-1] == d_in[W-1]) && (add_im[W-1] != b_in[W-1]);
            end
            OP_CSUB: begin
                s_re  = sub_re[W-1:0];
                s_im  = sub_im[W-1:0];
                s_cr  = sub_re[W];
                s_ci  = sub_im[W];
                s_ovr = (a_in[W-1] != c_in[W-1]) && (sub_re[W-1] != a_in[W-1]);
                s_ovi = (b_in[W-1] != d_in[W-1]) && (sub_im[W-1] != b_in[W-1]);
            end
            OP_CINC: begin
                s_re  = a_in + W'(1);
                s_im  = b_in + W'(1);
                s_ovr = (a_in == {1'b0, {(W-1){1'b1}}});
                s_ovi = (b_in == {1'b0, {(W-1){1'b1}}});
            end
            OP_CDEC: begin
                s_re  = a_in - W'(1);
                s_im  = b_in - W'(1);
                s_ovr = (a_in == {1'b1, {(W-1){1'b0}}});
                s_ovi = (b_in == {1'b1, {(W-1){1'b0}}});
            end
            OP_CSWAP: begin
                s_re = b_in;
                s_im = a_in;
            end
            OP_CMUL: begin
            end
            OP_CDIV: begin
                s_ze = 1'b1;
            end
`ifdef CALU_LOGIC_EN
            OP_AND: begin
                s_re = a_in & c_in;
                s_im = b_in & d_in;
            end
            OP_OR: begin
                s_re = a_in | c_in;
                s_im = b_in | d_in;
            end
            OP_XOR: begin
                s_re = a_in ^ c_in;
                s_im = b_in ^ d_in;
            end
            OP_XNOR: begin
                s_re = ~(a_in ^ c_in);
                s_im = ~(b_in ^ d_in);
            end
            OP_NAND: begin
                s_re = ~(a_in & c_in);
                s_im = ~(b_in & d_in);
            end
            OP_NOR: begin
                s_re = ~(a_in | c_in);
                s_im = ~(b_in | d_in);
            end
`endif
            default: s_ill = 1'b1;
        endcase
        s_flags            = value_flags(s_re, s_im);
        s_flags[FLAG_CR]   = s_cr;
        s_flags[FLAG_CI]   = s_ci;
        s_flags[FLAG_OR]   = s_ovr;
        s_flags[FLAG_OI]   = s_ovi;
        s_flags[FLAG_ZER]  = s_ze;
        s_flags[FLAG_ZEI]  = s_ze;
        if (s_ill) begin
            s_flags           = '0;
            s_flags[FLAG_ILL] = 1'b1;
        end
    end

    logic [W-1:0] div_re, div_im;
    assign div_re = fits_w(res_re) ? res_re[W-1:0] : '0;
    assign div_im = fits_w(res_im) ? res_im[W-1:0] : '0;

    always_comb begin
        state_d = state_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        zout_d  = zout_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    z1_d = z1;
                    z2_d = z2;
                    if (opcode == OP_CMUL) begin
                        state_d = S_MUL;
                    end else if (div_start) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                        zout_d  = s_ill ? '0 : {s_re, s_im};
                        flags_d = s_flags;
                    end
                end
            end
            S_MUL: begin
                state_d          = S_DONE;
                zout_d           = {mul_re_x[W-1:0], mul_im_x[W-1:0]};
                flags_d          = value_flags(mul_re_x[W-1:0], mul_im_x[W-1:0]);
                flags_d[FLAG_OR] = !fits_w(mul_re_x);
                flags_d[FLAG_OI] = !fits_w(mul_im_x);
            end
            S_DIV: begin
                if (done_re && done_im) begin
                    state_d            = S_DONE;
                    zout_d             = {div_re, div_im};
                    flags_d            = value_flags(div_re, div_im);
                    flags_d[FLAG_DVFR] = !fits_w(res_re);
                    flags_d[FLAG_DVFI] = !fits_w(res_im);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            z1_q    <= '0;
            z2_q    <= '0;
            zout_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            zout_q  <= zout_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign zout      = zout_q;
    assign flags     = flags_q;

endmodule
